// File: rtl/sqrt_scheduler.sv
// sqrt_scheduler: shares one iterative square-root core between four requesters.
// Requesters are granted round-robin. The winner's operand is sent to the core
// with a start pulse. The root, or a timeout abort, is then held for that
// requester until it accepts it.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | searching for the next requester after lastGrant
//   ISSUE    | one-cycle start pulse, operand already on sqrtData
//   WAIT     | waiting for sqrtDone, counting towards TIMEOUT
//   RESPOND  | presenting root/abort to the granted requester
module sqrt_scheduler #(
    parameter int IN_WIDTH  = 142,
    parameter int OUT_WIDTH = 72,
    parameter int TIMEOUT   = 80     // legal range 2..255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [3:0]              reqValid,
    input  logic [4*IN_WIDTH-1:0]   reqData,
    output logic [3:0]              reqReady,
    output logic                    sqrtStart,
    output logic [IN_WIDTH-1:0]     sqrtData,
    input  logic                    sqrtDone,
    input  logic [OUT_WIDTH-1:0]    sqrtResult,
    output logic [3:0]              respValid,
    output logic [OUT_WIDTH-1:0]    respData,
    output logic                    respError,
    input  logic [3:0]              respReady,
    output logic                    busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    // Terminal count of the WAIT counter; it starts at 0 in the first WAIT cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [1:0]             grant_q, grant_d;
    logic [1:0]             last_q, last_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [IN_WIDTH-1:0]    op_q, op_d;
    logic [3:0]             rvalid_q, rvalid_d;
    logic [OUT_WIDTH-1:0]   rdata_q, rdata_d;
    logic                   rerr_q, rerr_d;

    logic [IN_WIDTH-1:0]    req_op [4];
    logic [1:0]             cand;
    logic [1:0]             winner;
    logic                   win_found;
    logic                   accept;

    // Split the packed operand bus into one slice per requester.
    for (genvar gk = 0; gk < 4; gk++) begin : g_slice
        assign req_op[gk] = reqData[gk*IN_WIDTH +: IN_WIDTH];
    end

    // Round-robin search: scan last+4 down to last+1 so the nearest one wins.
    // last+4 wraps to last itself, which gives the previous winner lowest priority.
    always_comb begin
        cand      = '0;
        winner    = last_q;
        win_found = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            cand = last_q + 2'(i);
            if (reqValid[cand]) begin
                winner    = cand;
                win_found = 1'b1;
            end
        end
    end

    // reqReady is gated by reset so nothing is offered while reset is held.
    assign reqReady = (reset && (state_q == ST_IDLE) && win_found) ? (4'b0001 << winner) : 4'b0000;
    assign accept   = (reqReady != 4'b0000);

    // Next-state and datapath updates for the four-state sequence.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = req_op[winner];
                    grant_d = winner;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = 8'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done pulse on the last allowed cycle still counts as success.
                if (sqrtDone) begin
                    rdata_d  = sqrtResult;
                    rerr_d   = 1'b0;
                    rvalid_d = 4'b0001 << grant_q;
                    state_d  = ST_RESPOND;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d  = '0;
                    rerr_d   = 1'b1;
                    rvalid_d = 4'b0001 << grant_q;
                    state_d  = ST_RESPOND;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESPOND: begin
                // Only the granted requester can retire the response.
                if (respReady[grant_q]) begin
                    last_d   = grant_q;
                    rvalid_d = 4'b0000;
                    rerr_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= 2'd0;
            last_q   <= 2'd3;
            cnt_q    <= 8'd0;
            op_q     <= '0;
            rvalid_q <= 4'b0000;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
        end
    end

    assign sqrtStart = (state_q == ST_ISSUE);
    assign sqrtData  = op_q;
    assign respValid = rvalid_q;
    assign respData  = rdata_q;
    assign respError = rerr_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sqrt_scheduler.sv
// Self-checking bench for sqrt_scheduler: a vector table of transactions,
// hand-written corner sequences, then a randomized phase checked against a
// transaction-level model of the round-robin scheduler.
module tb_sqrt_scheduler;
    localparam int IW = 142;
    localparam int OW = 72;
    localparam int TO = 80;

    logic            clock = 1'b0;
    logic            reset;
    logic [3:0]      reqValid, reqReady, respValid, respReady;
    logic [4*IW-1:0] reqData;
    logic            sqrtStart, sqrtDone, respError, busy;
    logic [IW-1:0]   sqrtData;
    logic [OW-1:0]   sqrtResult, respData;

    always #5 clock = ~clock;

    sqrt_scheduler #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .reqValid(reqValid), .reqData(reqData), .reqReady(reqReady),
        .sqrtStart(sqrtStart), .sqrtData(sqrtData),
        .sqrtDone(sqrtDone), .sqrtResult(sqrtResult),
        .respValid(respValid), .respData(respData), .respError(respError),
        .respReady(respReady), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [IW-1:0] ops [4];

    // Behavioural square-root core: answers core_delay cycles after start (0 = never).
    int            core_delay = 0;
    int            cd = 0;
    logic          mdl_done = 1'b0;
    logic [OW-1:0] mdl_res = '0;
    logic [OW-1:0] pend_res = '0;
    logic          inj_done = 1'b0;
    logic [OW-1:0] inj_res = '0;

    assign sqrtDone   = mdl_done | inj_done;
    assign sqrtResult = inj_done ? inj_res : mdl_res;

    function automatic logic [OW-1:0] isqrt(input logic [IW-1:0] v);
        logic [OW-1:0]  r;
        logic [OW-1:0]  t;
        logic [143:0]   p;
        r = '0;
        for (int b = 70; b >= 0; b--) begin
            t = r | (72'd1 << b);
            p = 144'(t) * 144'(t);
            if (p <= 144'(v)) r = t;
        end
        return r;
    endfunction

    function automatic logic [IW-1:0] sq(input logic [OW-1:0] r);
        logic [143:0] p;
        p = 144'(r) * 144'(r);
        return p[IW-1:0];
    endfunction

    function automatic logic [IW-1:0] rand_op();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[IW-1:0];
    endfunction

    function automatic int rr_pick(input logic [3:0] v, input int last);
        for (int i = 1; i <= 4; i++)
            if (v[(last + i) % 4]) return (last + i) % 4;
        return -1;
    endfunction

    always @(posedge clock) begin
        #1;
        mdl_done = 1'b0;
        if (cd != 0) begin
            cd = cd - 1;
            if (cd == 0) begin
                mdl_done = 1'b1;
                mdl_res  = pend_res;
            end
        end
        if (sqrtStart) begin
            cd       = core_delay;
            pend_res = isqrt(sqrtData);
        end
    end

    task automatic chk(input string name, input logic [143:0] got, input logic [143:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic set_req(input logic [3:0] rv, input logic [OW-1:0] root);
        for (int k = 0; k < 4; k++) begin
            ops[k] = sq(root + 72'(k));
            reqData[k*IW +: IW] = ops[k];
        end
        reqValid = rv;
    endtask

    // One full transaction started in the current (idle) cycle; ends in the
    // first idle cycle after the response is taken.
    task automatic run_txn(input logic [3:0] rv, input logic [OW-1:0] root, input int g, input int d);
        logic [3:0] oh;
        oh = 4'b0001 << g;
        set_req(rv, root);
        respReady  = 4'b1111;
        core_delay = d;
        #1;
        chk("grant_ready", 144'(reqReady), 144'(oh));
        chk("idle_busy", 144'(busy), 144'(1'b0));
        step(); #1;
        chk("start_pulse", 144'(sqrtStart), 144'(1'b1));
        chk("start_data", 144'(sqrtData), 144'(sq(root + 72'(g))));
        for (int c = 2; c <= d + 1; c++) begin
            step(); #1;
            chk("early_resp", 144'(respValid), 144'(4'b0000));
        end
        step(); #1;
        chk("resp_valid", 144'(respValid), 144'(oh));
        chk("resp_data", 144'(respData), 144'(root + 72'(g)));
        chk("resp_err", 144'(respError), 144'(1'b0));
        step(); #1;
        chk("b2b_idle", 144'(busy), 144'(1'b0));
        chk("b2b_clear", 144'(respValid), 144'(4'b0000));
    endtask

    typedef struct {
        logic [3:0]    rv;
        logic [OW-1:0] root;
        int            grant;
        int            delay;
    } vec_t;

    vec_t          vecs [12];
    logic [OW-1:0] hold_root;
    int            m_last, m_grant, m_acc, m_resp, w, clr;
    logic          m_busy, m_err;
    logic [IW-1:0] m_op;
    logic [OW-1:0] m_data;
    logic [3:0]    exp_rv, exp_ready;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_cmp %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{4'b0001, 72'd12, 0, 2};
        vecs[1]  = '{4'b1111, 72'd1000, 1, 3};
        vecs[2]  = '{4'b1111, 72'h3F_FFFF_FFFF_FFFF_FFF0, 2, 5};
        vecs[3]  = '{4'b1111, 72'h12_3456_789A_BCDE_F012, 3, 2};
        vecs[4]  = '{4'b1111, 72'd77, 0, 4};
        vecs[5]  = '{4'b0010, 72'd65535, 1, 2};
        vecs[6]  = '{4'b1001, 72'h7_0000_0000_0001, 3, 3};
        vecs[7]  = '{4'b1001, 72'd5, 0, 2};
        vecs[8]  = '{4'b0110, 72'd123456789, 1, 6};
        vecs[9]  = '{4'b1100, 72'd0, 2, 2};
        vecs[10] = '{4'b0001, 72'h40_0000_0000_0000_0000, 0, 2};
        vecs[11] = '{4'b1110, 72'd31, 1, 3};

        reset = 1'b0; reqValid = 4'b0000; reqData = '0; respReady = 4'b0000;
        step(); step();
        reqValid = 4'b1111;
        #1;
        chk("rst_ready", 144'(reqReady), 144'(4'b0000));
        chk("rst_busy", 144'(busy), 144'(1'b0));
        chk("rst_start", 144'(sqrtStart), 144'(1'b0));
        chk("rst_sdata", 144'(sqrtData), 144'(0));
        chk("rst_rvalid", 144'(respValid), 144'(4'b0000));
        chk("rst_rdata", 144'(respData), 144'(0));
        chk("rst_rerr", 144'(respError), 144'(1'b0));
        reqValid = 4'b0000;
        reset = 1'b1;
        step();

        // Table: round-robin order, operand delivery, latency, back-to-back.
        for (int i = 0; i < 12; i++)
            run_txn(vecs[i].rv, vecs[i].root, vecs[i].grant, vecs[i].delay);

        // Response held while respReady is low or only on non-granted bits.
        hold_root = 72'hABC_DEF0_1234;
        set_req(4'b0100, hold_root);
        respReady = 4'b0000; core_delay = 4;
        #1;
        chk("hold_ready", 144'(reqReady), 144'(4'b0100));
        step(); reqValid = 4'b0000;
        for (int c = 2; c <= 6; c++) step();
        #1;
        chk("hold_first", 144'(respValid), 144'(4'b0100));
        respReady = 4'b1011;
        for (int c = 0; c < 10; c++) begin
            step(); #1;
            chk("hold_valid", 144'(respValid), 144'(4'b0100));
            chk("hold_data", 144'(respData), 144'(hold_root + 72'd2));
            chk("hold_busy", 144'(busy), 144'(1'b1));
        end
        respReady = 4'b0100;
        step(); #1;
        chk("hold_release", 144'(busy), 144'(1'b0));

        // Timeout abort, then a late done in RESPOND must be ignored.
        set_req(4'b1000, 72'd999);
        respReady = 4'b0000; core_delay = 0;
        #1;
        chk("to_ready", 144'(reqReady), 144'(4'b1000));
        step(); reqValid = 4'b0000;
        #1;
        chk("to_start", 144'(sqrtStart), 144'(1'b1));
        for (int c = 2; c <= TO + 1; c++) begin
            step(); #1;
            chk("to_early", 144'(respValid), 144'(4'b0000));
        end
        step(); #1;
        chk("to_valid", 144'(respValid), 144'(4'b1000));
        chk("to_data", 144'(respData), 144'(0));
        chk("to_err", 144'(respError), 144'(1'b1));
        inj_res = 72'h55; inj_done = 1'b1;
        step(); inj_done = 1'b0;
        #1;
        chk("late_valid", 144'(respValid), 144'(4'b1000));
        chk("late_data", 144'(respData), 144'(0));
        chk("late_err", 144'(respError), 144'(1'b1));
        respReady = 4'b1000;
        step(); #1;
        chk("to_release", 144'(busy), 144'(1'b0));
        chk("to_errclr", 144'(respError), 144'(1'b0));

        // Reset during WAIT; lastGrant must return to 3.
        run_txn(4'b0010, 72'd4242, 1, 2);
        set_req(4'b0100, 72'd777);
        respReady = 4'b0000; core_delay = 6;
        #1;
        chk("rw_ready", 144'(reqReady), 144'(4'b0100));
        step(); reqValid = 4'b0000;
        step(); step();
        reset = 1'b0; reqValid = 4'b1111;
        #1;
        chk("rw_gate", 144'(reqReady), 144'(4'b0000));
        step(); #1;
        chk("rw_ready0", 144'(reqReady), 144'(4'b0000));
        chk("rw_busy", 144'(busy), 144'(1'b0));
        chk("rw_start", 144'(sqrtStart), 144'(1'b0));
        chk("rw_sdata", 144'(sqrtData), 144'(0));
        chk("rw_rvalid", 144'(respValid), 144'(4'b0000));
        chk("rw_rdata", 144'(respData), 144'(0));
        chk("rw_rerr", 144'(respError), 144'(1'b0));
        reset = 1'b1; reqValid = 4'b0000;
        for (int c = 0; c < 8; c++) begin
            step(); #1;
            chk("rw_noresp", 144'(respValid), 144'(4'b0000));
            chk("rw_idle", 144'(busy), 144'(1'b0));
        end
        run_txn(4'b1111, 72'd31337, 0, 3);

        // Randomized traffic against a transaction-level model.
        reqValid = 4'b0000; respReady = 4'b0000;
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
        m_last = 3; m_busy = 1'b0; m_grant = 0; m_acc = 0; m_resp = 0;
        m_op = '0; m_data = '0; m_err = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (!reqValid[k] && $urandom_range(2) == 0) begin
                    ops[k] = ($urandom_range(3) == 0) ? IW'($urandom_range(10000)) : rand_op();
                    reqData[k*IW +: IW] = ops[k];
                    reqValid[k] = 1'b1;
                end
            end
            respReady = 4'($urandom);
            #1;
            w = m_busy ? -1 : rr_pick(reqValid, m_last);
            exp_ready = (w >= 0) ? (4'b0001 << w) : 4'b0000;
            chk("rnd_ready", 144'(reqReady), 144'(exp_ready));
            chk("rnd_busy", 144'(busy), 144'(m_busy));
            chk("rnd_start", 144'(sqrtStart), 144'(m_busy && (c == m_acc + 1)));
            if (m_busy && (c == m_acc + 1))
                chk("rnd_sdata", 144'(sqrtData), 144'(m_op));
            exp_rv = (m_busy && (c >= m_resp)) ? (4'b0001 << m_grant) : 4'b0000;
            chk("rnd_rvalid", 144'(respValid), 144'(exp_rv));
            if (exp_rv != 4'b0000) begin
                chk("rnd_rdata", 144'(respData), 144'(m_data));
                chk("rnd_rerr", 144'(respError), 144'(m_err));
            end
            clr = -1;
            if (exp_rv != 4'b0000 && respReady[m_grant]) begin
                m_busy = 1'b0;
                m_last = m_grant;
            end else if (w >= 0) begin
                m_busy  = 1'b1;
                m_grant = w;
                m_acc   = c;
                m_op    = ops[w];
                clr     = w;
                core_delay = ($urandom_range(15) == 0) ? 0 : int'($urandom_range(10, 2));
                if (core_delay == 0) begin
                    m_resp = c + TO + 2;
                    m_data = '0;
                    m_err  = 1'b1;
                end else begin
                    m_resp = c + core_delay + 2;
                    m_data = isqrt(m_op);
                    m_err  = 1'b0;
                end
            end
            step();
            if (clr >= 0) reqValid[clr] = 1'b0;
        end

        reqValid = 4'b0000;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
